// File: rtl/cc_arbiter_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cc_arbiter_n                                                 |
// | Description : Memory and coherence controller for CPUS processors, each   |
// |               with one icache and one dcache. Arbitrates every cache       |
// |               request onto the single RAM port with round-robin fairness   |
// |               across CPUs, snoops the other dcaches for coherent reads and |
// |               performs cache-to-cache transfers with a simultaneous RAM    |
// |               writeback of the supplied word.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Build option:                                                              |
// |   COHERENCE_SNOOP_EN  defined   -> SNOOP and C2C states present           |
// |                       undefined -> every dREN goes straight to DREAD,     |
// |                                    ccwrite/cctrans ignored, snoop outputs |
// |                                    tied to 0                               |
// +----------------------------------------------------------------------------+
// | Ports (word = 32 bits, [N] = one entry per CPU):                           |
// |   CLK, nRST            clock, asynchronous active-low reset               |
// |   iREN/dREN/dWEN [N]   icache read, dcache read, dcache write requests    |
// |   iaddr/daddr [N]      request addresses                                   |
// |   dstore [N]           dcache write data (also supplier data for C2C)     |
// |   ccwrite/cctrans [N]  dcache holds modified data / transition pending    |
// |   iwait/dwait [N]      1 = request not yet served                          |
// |   iload/dload [N]      returned data                                       |
// |   ccwait/ccinv [N]     snoop stall / invalidate snooped line              |
// |   ccsnoopaddr [N]      address being snooped                               |
// |   ramREN/ramWEN        RAM strobes                                         |
// |   ramaddr/ramstore     RAM address and write data                          |
// |   ramload              RAM read data                                       |
// |   ramstate             FREE=0, BUSY=1, ACCESS=2, ERROR=3                   |
// +----------------------------------------------------------------------------+

module cc_arbiter_n #(
  parameter int CPUS = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] iREN,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  logic [31:0]     iaddr       [CPUS],
  input  logic [31:0]     daddr       [CPUS],
  input  logic [31:0]     dstore      [CPUS],
  input  logic [CPUS-1:0] ccwrite,
  input  logic [CPUS-1:0] cctrans,
  output logic [CPUS-1:0] iwait,
  output logic [CPUS-1:0] dwait,
  output logic [31:0]     iload       [CPUS],
  output logic [31:0]     dload       [CPUS],
  output logic [CPUS-1:0] ccwait,
  output logic [CPUS-1:0] ccinv,
  output logic [31:0]     ccsnoopaddr [CPUS],
  output logic            ramREN,
  output logic            ramWEN,
  output logic [31:0]     ramaddr,
  output logic [31:0]     ramstore,
  input  logic [31:0]     ramload,
  input  logic [1:0]      ramstate
);

  localparam int         c_IDX_W      = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] c_RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IREAD  = 3'd1,
    ST_DREAD  = 3'd2,
    ST_DWRITE = 3'd3,
    ST_SNOOP  = 3'd4,
    ST_C2C    = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_idle_next;
  logic [c_IDX_W-1:0]   r_grant;
  logic [c_IDX_W-1:0]   r_rr_ptr;
  logic [c_IDX_W-1:0]   w_grant;
  logic [c_IDX_W-1:0]   w_cand;
  logic [c_IDX_W-1:0]   w_rr_next;
  logic                 w_any_req;
  logic                 w_active;
  logic                 w_done;

  // (base + ofs) mod CPUS; both operands are already below CPUS, so a single
  // conditional subtraction is enough.
  function automatic logic [c_IDX_W-1:0] wrap_add(input logic [c_IDX_W-1:0] base,
                                                  input logic [31:0]        ofs);
    logic [31:0] sum;
    sum = 32'(base) + ofs;
    if (sum >= 32'(CPUS)) begin
      sum = sum - 32'(CPUS);
    end
    return c_IDX_W'(sum);
  endfunction

  // --------------------------------------------------------------------------
  // Round-robin arbitration. The loop walks the offsets from farthest to
  // nearest so that the last hit, i.e. the CPU closest to rr_ptr, wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_any_req = 1'b0;
    w_grant   = r_rr_ptr;
    w_cand    = r_rr_ptr;
    for (int k = CPUS - 1; k >= 0; k--) begin
      w_cand = wrap_add(r_rr_ptr, 32'(k));
      if (iREN[w_cand] || dREN[w_cand] || dWEN[w_cand]) begin
        w_any_req = 1'b1;
        w_grant   = w_cand;
      end
    end
  end

  // Within the granted CPU a write-back beats a data read beats an ifetch.
  always_comb begin
    if (dWEN[w_grant]) begin
      w_idle_next = ST_DWRITE;
    end else if (dREN[w_grant]) begin
`ifdef COHERENCE_SNOOP_EN
      w_idle_next = cctrans[w_grant] ? ST_SNOOP : ST_DREAD;
`else
      w_idle_next = ST_DREAD;
`endif
    end else if (iREN[w_grant]) begin
      w_idle_next = ST_IREAD;
    end else begin
      w_idle_next = ST_IDLE;
    end
  end

  assign w_rr_next = wrap_add(r_grant, 32'd1);

`ifdef COHERENCE_SNOOP_EN
  logic [c_IDX_W-1:0] r_supplier;
  logic [c_IDX_W-1:0] w_sup;
  logic [c_IDX_W-1:0] w_sup_cand;
  logic               w_sup_found;

  // Supplier: first other dcache holding modified data, searching upward
  // from grant+1. Offset 0 (the requester itself) is never considered.
  always_comb begin
    w_sup_found = 1'b0;
    w_sup       = r_grant;
    w_sup_cand  = r_grant;
    for (int k = CPUS - 1; k >= 1; k--) begin
      w_sup_cand = wrap_add(r_grant, 32'(k));
      if (ccwrite[w_sup_cand]) begin
        w_sup_found = 1'b1;
        w_sup       = w_sup_cand;
      end
    end
  end
`else
  // Coherence inputs have no function without the snoop phase.
  logic w_unused;
  assign w_unused = ^{ccwrite, cctrans};
`endif

  // --------------------------------------------------------------------------
  // The granted request must stay asserted for the whole transaction; a
  // withdrawn request aborts the transaction without a completion pulse.
  // --------------------------------------------------------------------------
  always_comb begin
    case (r_state)
      ST_IREAD:                   w_active = iREN[r_grant];
      ST_DWRITE:                  w_active = dWEN[r_grant];
      ST_DREAD, ST_SNOOP, ST_C2C: w_active = dREN[r_grant];
      default:                    w_active = 1'b0;
    endcase
  end

  assign w_done = w_active && (ramstate == c_RAM_ACCESS) && (r_state != ST_SNOOP);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
`ifdef COHERENCE_SNOOP_EN
      r_supplier <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= w_idle_next;
            r_grant <= w_grant;
          end
        end
`ifdef COHERENCE_SNOOP_EN
        // Snoop lasts one cycle regardless of the RAM state.
        ST_SNOOP: begin
          if (!w_active) begin
            r_state <= ST_IDLE;
          end else if (w_sup_found) begin
            r_supplier <= w_sup;
            r_state    <= ST_C2C;
          end else begin
            r_state <= ST_DREAD;
          end
        end
`endif
        // RAM phases: BUSY/FREE/ERROR simply hold; only ACCESS completes and
        // advances the round-robin pointer.
        default: begin
          if (!w_active) begin
            r_state <= ST_IDLE;
          end else if (w_done) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_rr_next;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ccwait   = '0;
    ccinv    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int i = 0; i < CPUS; i++) begin
      iload[i]       = ramload;
      dload[i]       = ramload;
      ccsnoopaddr[i] = '0;
    end

    case (r_state)
      ST_IREAD: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[r_grant];
        if (w_done) begin
          iwait[r_grant] = 1'b0;
        end
      end
      ST_DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[r_grant];
        if (w_done) begin
          dwait[r_grant] = 1'b0;
        end
      end
      ST_DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_grant];
        ramstore = dstore[r_grant];
        if (w_done) begin
          dwait[r_grant] = 1'b0;
        end
      end
`ifdef COHERENCE_SNOOP_EN
      ST_SNOOP: begin
        for (int i = 0; i < CPUS; i++) begin
          if (c_IDX_W'(i) != r_grant) begin
            ccwait[i]      = 1'b1;
            ccsnoopaddr[i] = daddr[r_grant];
            ccinv[i]       = ccwrite[r_grant];
          end
        end
      end
      // The supplier's word goes to the requester and to RAM in one cycle;
      // the supplier stays stalled on the snooped line until completion.
      ST_C2C: begin
        ramWEN                  = 1'b1;
        ramaddr                 = daddr[r_supplier];
        ramstore                = dstore[r_supplier];
        dload[r_grant]          = dstore[r_supplier];
        ccwait[r_supplier]      = 1'b1;
        ccsnoopaddr[r_supplier] = daddr[r_grant];
        if (w_done) begin
          dwait[r_grant]    = 1'b0;
          dwait[r_supplier] = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cc_arbiter_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cc_arbiter_n                                              |
// | Description : Self-checking bench for cc_arbiter_n with CPUS=4. A          |
// |               transaction-level reference model predicts every output on   |
// |               each cycle; directed scenarios add literal expectations.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_cc_arbiter_n;

  localparam int         CPUS      = 4;
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
`ifdef COHERENCE_SNOOP_EN
  localparam bit SNOOP_EN = 1'b1;
`else
  localparam bit SNOOP_EN = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            nRST;
  logic [CPUS-1:0] iREN, dREN, dWEN, ccwrite, cctrans;
  logic [CPUS-1:0] iwait, dwait, ccwait, ccinv;
  logic [31:0]     iaddr [CPUS], daddr [CPUS], dstore [CPUS];
  logic [31:0]     iload [CPUS], dload [CPUS], ccsnoopaddr [CPUS];
  logic            ramREN, ramWEN;
  logic [31:0]     ramaddr, ramstore, ramload;
  logic [1:0]      ramstate;

  always #5 CLK = ~CLK;

  cc_arbiter_n #(.CPUS(CPUS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .cctrans(cctrans),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one outstanding transaction record (who, what kind,
  // supplier) plus the round-robin start point.
  // ---------------------------------------------------------------------------
  localparam int K_NONE = 0, K_IRD = 1, K_DRD = 2, K_DWR = 3, K_SNP = 4, K_C2C = 5;
  int m_kind, m_cpu, m_sup, m_rr;
  bit m_found;

  function automatic bit wanted(input int kind, input int c);
    case (kind)
      K_IRD:               return iREN[c];
      K_DWR:               return dWEN[c];
      K_DRD, K_SNP, K_C2C: return dREN[c];
      default:             return 1'b0;
    endcase
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_kind = K_NONE; m_rr = 0; m_cpu = 0; m_sup = 0;
    end else if (m_kind == K_NONE) begin
      m_found = 1'b0;
      for (int k = 0; k < CPUS; k++) begin
        if (!m_found && (iREN[(m_rr+k)%CPUS] || dREN[(m_rr+k)%CPUS] || dWEN[(m_rr+k)%CPUS])) begin
          m_found = 1'b1;
          m_cpu   = (m_rr + k) % CPUS;
        end
      end
      if (m_found)
        m_kind = dWEN[m_cpu] ? K_DWR :
                 dREN[m_cpu] ? ((SNOOP_EN && cctrans[m_cpu]) ? K_SNP : K_DRD) : K_IRD;
    end else if (!wanted(m_kind, m_cpu)) begin
      m_kind = K_NONE;
    end else if (m_kind == K_SNP) begin
      m_sup = -1;
      for (int k = 1; k < CPUS; k++)
        if (m_sup < 0 && ccwrite[(m_cpu+k)%CPUS]) m_sup = (m_cpu + k) % CPUS;
      m_kind = (m_sup >= 0) ? K_C2C : K_DRD;
    end else if (ramstate == RS_ACCESS) begin
      m_kind = K_NONE;
      m_rr   = (m_cpu + 1) % CPUS;
    end
  end

  logic [CPUS-1:0] e_iwait, e_dwait, e_ccwait, e_ccinv;
  logic            e_ren, e_wen, e_done;
  logic [31:0]     e_addr, e_store;
  logic [31:0]     e_dload [CPUS], e_snaddr [CPUS];

  always @(negedge CLK) begin
    e_iwait = '1; e_dwait = '1; e_ccwait = '0; e_ccinv = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    for (int i = 0; i < CPUS; i++) begin e_dload[i] = ramload; e_snaddr[i] = '0; end
    e_done = (m_kind inside {K_IRD, K_DRD, K_DWR, K_C2C}) && wanted(m_kind, m_cpu) &&
             (ramstate == RS_ACCESS);
    case (m_kind)
      K_IRD: begin
        e_ren = 1'b1; e_addr = iaddr[m_cpu];
        if (e_done) e_iwait[m_cpu] = 1'b0;
      end
      K_DRD: begin
        e_ren = 1'b1; e_addr = daddr[m_cpu];
        if (e_done) e_dwait[m_cpu] = 1'b0;
      end
      K_DWR: begin
        e_wen = 1'b1; e_addr = daddr[m_cpu]; e_store = dstore[m_cpu];
        if (e_done) e_dwait[m_cpu] = 1'b0;
      end
      K_SNP: begin
        for (int j = 0; j < CPUS; j++) if (j != m_cpu) begin
          e_ccwait[j] = 1'b1; e_snaddr[j] = daddr[m_cpu]; e_ccinv[j] = ccwrite[m_cpu];
        end
      end
      K_C2C: begin
        e_wen = 1'b1; e_addr = daddr[m_sup]; e_store = dstore[m_sup];
        e_dload[m_cpu] = dstore[m_sup];
        e_ccwait[m_sup] = 1'b1; e_snaddr[m_sup] = daddr[m_cpu];
        if (e_done) begin e_dwait[m_cpu] = 1'b0; e_dwait[m_sup] = 1'b0; end
      end
      default: ;
    endcase
    chk("model_iwait",    32'(iwait),    32'(e_iwait));
    chk("model_dwait",    32'(dwait),    32'(e_dwait));
    chk("model_ccwait",   32'(ccwait),   32'(e_ccwait));
    chk("model_ccinv",    32'(ccinv),    32'(e_ccinv));
    chk("model_ramREN",   32'(ramREN),   32'(e_ren));
    chk("model_ramWEN",   32'(ramWEN),   32'(e_wen));
    chk("model_ramaddr",  ramaddr,       e_addr);
    chk("model_ramstore", ramstore,      e_store);
    for (int i = 0; i < CPUS; i++) begin
      chk($sformatf("model_iload[%0d]", i), iload[i], ramload);
      chk($sformatf("model_dload[%0d]", i), dload[i], e_dload[i]);
      chk($sformatf("model_snoopaddr[%0d]", i), ccsnoopaddr[i], e_snaddr[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    for (int i = 0; i < CPUS; i++) begin iaddr[i] = '0; daddr[i] = '0; dstore[i] = '0; end
    ramstate = RS_FREE; ramload = '0;
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1 nRST = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
  endtask

  int          rr_exp [5] = '{0, 1, 2, 3, 0};
  logic [1:0]  stall_seq [4];
  logic [3:0]  expw;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    stall_seq = '{RS_BUSY, RS_ERROR, RS_BUSY, RS_ACCESS};
    nRST = 1'b0;
    idle_inputs();

    // Reset with random inputs
    for (int n = 0; n < 3; n++) begin
      @(posedge CLK); #1;
      iREN = 4'($urandom); dREN = 4'($urandom); dWEN = 4'($urandom);
      ccwrite = 4'($urandom); cctrans = 4'($urandom); ramstate = 2'($urandom);
      ramload = $urandom;
      for (int i = 0; i < CPUS; i++) begin
        iaddr[i] = $urandom; daddr[i] = $urandom; dstore[i] = $urandom;
      end
      @(negedge CLK);
      chk("rst_iwait", 32'(iwait), 32'hF);
      chk("rst_dwait", 32'(dwait), 32'hF);
      chk("rst_strobes", 32'({ramREN, ramWEN}), 32'h0);
      chk("rst_ramaddr", ramaddr, 32'h0);
    end
    @(posedge CLK); #1 idle_inputs(); nRST = 1'b1;

    // First transaction after reset
    @(posedge CLK); #1;
    iREN[0] = 1'b1; iaddr[0] = 32'h100; ramstate = RS_ACCESS; ramload = 32'h1234_5678;
    @(posedge CLK); @(negedge CLK);
    chk("t1_ramREN", 32'(ramREN), 32'h1);
    chk("t1_ramaddr", ramaddr, 32'h100);
    chk("t1_iwait", 32'(iwait), 32'hE);
    chk("t1_iload0", iload[0], 32'h1234_5678);
    @(posedge CLK); #1 iREN[0] = 1'b0;

    // Round-robin fairness from reset
    pulse_reset();
    for (int i = 0; i < CPUS; i++) iaddr[i] = 32'h1000 + 32'(i * 4);
    iREN = '1; ramstate = RS_ACCESS;
    for (int n = 0; n < 5; n++) begin
      @(posedge CLK); @(negedge CLK);
      expw = ~(4'b0001 << rr_exp[n]);
      chk("rr_ramaddr", ramaddr, 32'h1000 + 32'(rr_exp[n] * 4));
      chk("rr_iwait", 32'(iwait), 32'(expw));
      @(posedge CLK); @(negedge CLK);
      chk("rr_gap", 32'(ramREN), 32'h0);
    end
    #1 iREN = '0;

    // Intra-CPU priority: write-back before ifetch (rr now points at CPU1)
    dWEN[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'hDEAD;
    iREN[1] = 1'b1; iaddr[1] = 32'h300;
    @(posedge CLK); @(negedge CLK);
    chk("prio_ramWEN", 32'(ramWEN), 32'h1);
    chk("prio_ramaddr_w", ramaddr, 32'h200);
    chk("prio_ramstore", ramstore, 32'hDEAD);
    chk("prio_dwait", 32'(dwait), 32'hD);
    chk("prio_iwait_held", 32'(iwait), 32'hF);
    @(posedge CLK); #1 dWEN[1] = 1'b0;
    @(negedge CLK);
    chk("prio_gap", 32'({ramREN, ramWEN}), 32'h0);
    @(posedge CLK); @(negedge CLK);
    chk("prio_ramaddr_i", ramaddr, 32'h300);
    chk("prio_iwait", 32'(iwait), 32'hD);
    @(posedge CLK); #1 iREN[1] = 1'b0;

    // Coherent read by CPU0 with CPU1 holding modified data
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h40;
    ccwrite[1] = 1'b1; dstore[1] = 32'hBEEF; daddr[1] = 32'h44;
    ramload = 32'h5555_AAAA; ramstate = RS_ACCESS;
    @(posedge CLK); @(negedge CLK);
`ifdef COHERENCE_SNOOP_EN
    chk("snoop_ccwait", 32'(ccwait), 32'hE);
    chk("snoop_addr1", ccsnoopaddr[1], 32'h40);
    chk("snoop_ccinv", 32'(ccinv), 32'h0);
    chk("snoop_strobes", 32'({ramREN, ramWEN}), 32'h0);
    @(posedge CLK); @(negedge CLK);
    chk("c2c_ramWEN", 32'(ramWEN), 32'h1);
    chk("c2c_ramaddr", ramaddr, 32'h44);
    chk("c2c_ramstore", ramstore, 32'hBEEF);
    chk("c2c_dload0", dload[0], 32'hBEEF);
    chk("c2c_dload1", dload[1], 32'h5555_AAAA);
    chk("c2c_dwait", 32'(dwait), 32'hC);
    chk("c2c_ccwait", 32'(ccwait), 32'h2);
`else
    chk("nosnoop_ramREN", 32'(ramREN), 32'h1);
    chk("nosnoop_ramaddr", ramaddr, 32'h40);
    chk("nosnoop_ccwait", 32'(ccwait), 32'h0);
    chk("nosnoop_dload0", dload[0], 32'h5555_AAAA);
    chk("nosnoop_dwait", 32'(dwait), 32'hE);
`endif
    @(posedge CLK); #1 dREN = '0; cctrans = '0; ccwrite = '0;

    // RAM stall (BUSY, ERROR, BUSY) then ACCESS; rr points at CPU1, CPU2 alone
    iREN[2] = 1'b1; iaddr[2] = 32'h500; ramstate = stall_seq[0];
    @(posedge CLK);
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      chk("stall_iwait", 32'(iwait), 32'hF);
      chk("stall_ramaddr", ramaddr, 32'h500);
      @(posedge CLK); #1 ramstate = stall_seq[n+1];
    end
    @(negedge CLK);
    chk("stall_done_iwait", 32'(iwait), 32'hB);
    @(posedge CLK); #1 iREN[2] = 1'b0;

    // Withdrawal during BUSY: no pulse, rr stays at CPU3
    iREN[3] = 1'b1; iaddr[3] = 32'h600; ramstate = RS_BUSY;
    @(posedge CLK); @(negedge CLK);
    chk("wd_ramaddr", ramaddr, 32'h600);
    @(posedge CLK); #1 iREN[3] = 1'b0; ramstate = RS_ACCESS;
    @(negedge CLK);
    chk("wd_no_pulse", 32'(iwait), 32'hF);
    @(posedge CLK); @(negedge CLK);
    chk("wd_idle", 32'(ramREN), 32'h0);
    #1 iREN[0] = 1'b1; iaddr[0] = 32'h700; iREN[3] = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("wd_rr_kept", ramaddr, 32'h600);
    chk("wd_rr_iwait", 32'(iwait), 32'h7);
    @(posedge CLK); #1 iREN[3] = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("wd_next_cpu0", ramaddr, 32'h700);
    @(posedge CLK); #1 iREN = '0;

    // Reset mid-transaction
    iREN[1] = 1'b1; iaddr[1] = 32'h800; ramstate = RS_BUSY;
    @(posedge CLK); @(negedge CLK);
    chk("rstmid_ramREN", 32'(ramREN), 32'h1);
    @(posedge CLK); #1 nRST = 1'b0; ramstate = RS_ACCESS;
    #1;
    chk("rstmid_iwait", 32'(iwait), 32'hF);
    chk("rstmid_strobe", 32'(ramREN), 32'h0);
    @(posedge CLK); #1 nRST = 1'b1; iREN = '0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cc_arbiter_n.md
# cc_arbiter_n

Parametrised memory and coherence controller for CPUS processors, each with one icache and one dcache. It arbitrates all cache requests onto the single RAM port with round-robin fairness across CPUs. It runs a snoop phase for coherent dcache transactions and performs cache-to-cache transfers with simultaneous RAM writeback. It sits between the per-CPU cache pairs and the RAM model, in place of the fixed two-CPU controller.

## Interface
- CPUS, 2: number of processors; any value ≥ 1.
- CLK  in  1: system clock; all state changes on the rising edge.
- nRST  in  1: asynchronous, active-low reset.
- iREN, dREN, dWEN  in  [CPUS]: per-CPU icache read, dcache read and dcache write requests.
- iaddr, daddr, dstore  in  word_t[CPUS]: request addresses and dcache write data.
- ccwrite, cctrans  in  [CPUS]: dcache intends modify / has data to supply; dcache state transition pending.
- iwait, dwait  out  [CPUS]: 1 = request not yet served.
- iload, dload  out  word_t[CPUS]: returned data.
- ccwait, ccinv  out  [CPUS]: snoop stall; invalidate snooped line.
- ccsnoopaddr  out  word_t[CPUS]: address being snooped.
- ramREN, ramWEN  out  1: RAM strobes.
- ramaddr, ramstore  out  word_t: RAM address and write data.
- ramload  in  word_t: RAM read data.
- ramstate  in  ramstate_t: FREE, BUSY, ACCESS or ERROR.

## Operation
- **States:** IDLE, IREAD, DREAD, DWRITE, SNOOP, C2C.
- **Arbitration in IDLE:** combinational over pending CPUs.
  - Search starts at rr_ptr and proceeds upward with wrap.
  - The first CPU with any request wins; this CPU is g.
  - Within g, the priority is dWEN > dREN > iREN.
  - g is registered with the state.
- **Next state from IDLE:**
  - dWEN → DWRITE.
  - dREN with cctrans[g]=1 (and COHERENCE_SNOOP_EN defined) → SNOOP.
  - dREN otherwise → DREAD.
  - iREN → IREAD.
  - No request → stay in IDLE.
- **IREAD:** ramREN=1, ramaddr=iaddr[g].
- **DREAD:** ramREN=1, ramaddr=daddr[g].
- **DWRITE:** ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g]. No snoop is performed for writebacks.
- **SNOOP:** lasts exactly 1 cycle. For every j≠g:
  - ccwait[j]=1.
  - ccsnoopaddr[j]=daddr[g].
  - ccinv[j]=ccwrite[g].
- **Supplier selection (end of SNOOP):**
  - The supplier s is the first j≠g, searching upward from g+1 with wrap, with ccwrite[j]=1.
  - A supplier exists → C2C; otherwise → DREAD.
- **C2C:**
  - ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
  - dload[g]=dstore[s].
  - ccwait[s] stays 1 and ccsnoopaddr[s] stays daddr[g].
- **Completion:** occurs in any RAM state when ramstate==ACCESS.
  - The served wait (iwait[g] or dwait[g]) is 0 for that cycle only.
  - In C2C, dwait[s]=0 in the same cycle.
  - Next state is IDLE and rr_ptr ← (g+1) mod CPUS.
- **Data outputs:** iload[i]=ramload for every i. dload[i]=ramload for every i, except dload[g] during C2C.
- **Defaults outside the above:** all waits are 1; all other outputs are 0.
- **RAM BUSY/FREE:** hold the current state and outputs.
- **RAM ERROR:** hold the current state and outputs (retry); waits remain 1.
- **Request withdrawn:** if g's active request deasserts before ACCESS, go to IDLE next cycle with no wait deassertion and rr_ptr unchanged.
- **Single word per transaction:** each transaction moves one word. Multi-word blocks are re-arbitrated per word, so other CPUs may interleave.

## Timing
- **Reset (async, nRST=0):**
  - state=IDLE, rr_ptr=0.
  - iwait and dwait all 1.
  - ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr and ramstore all 0.
- **Reset mid-transaction:** abandoned immediately; no completion pulse.
- **Latency:**
  - Request sampled at edge t; RAM strobe asserted in cycle t+1.
  - A coherent read spends cycle t+1 in SNOOP and strobes RAM at t+2.
  - Completion falls in the cycle ramstate==ACCESS, registered into IDLE at the following edge.
- **Minimum gap:** one IDLE cycle between back-to-back transactions. The next grant is decided in that IDLE cycle.
- **Simultaneous requests:** all requests arriving in the same cycle are resolved by rr_ptr; the losers keep waits at 1.
- **CPUS=1:** SNOOP always falls through to DREAD (no other caches).

## Configuration
- **COHERENCE_SNOOP_EN defined:** the SNOOP and C2C states are present, with the behaviour above.
- **COHERENCE_SNOOP_EN undefined:**
  - SNOOP and C2C are removed and cctrans/ccwrite are ignored.
  - Every dREN goes to DREAD.
  - ccwait, ccinv and ccsnoopaddr are tied to 0.

## Test plan
- **Reset values:** nRST low with random inputs → all waits 1, all strobes 0. Release nRST; CPU0 iREN, iaddr=0x100, ramstate=ACCESS → ramREN=1, ramaddr=0x100 one cycle later, iwait[0]=0 for that cycle.
- **Round-robin fairness:** CPUS=4, all iREN held, RAM always ACCESS → grants in order 0,1,2,3,0 with one IDLE cycle between each.
- **Intra-CPU priority:** CPU1 dWEN daddr=0x200 dstore=0xDEAD plus iREN simultaneously → DWRITE first (ramstore=0xDEAD, dwait[1]=0), then IREAD.
- **Cache-to-cache transfer:** CPU0 dREN cctrans=1 daddr=0x40, CPU1 ccwrite=1 dstore=0xBEEF → one SNOOP cycle with ccwait[1]=1, ccsnoopaddr[1]=0x40. Then C2C with ramWEN=1, ramstore=0xBEEF, dload[0]=0xBEEF, dwait[0]=dwait[1]=0 on ACCESS.
- **RAM stall and withdrawal:** ramstate BUSY for 3 cycles then ACCESS → waits stay 1 until ACCESS. Withdraw the request during BUSY → IDLE next cycle, no wait pulse.
- **Snoop compiled out:** repeat the cache-to-cache scenario without COHERENCE_SNOOP_EN → direct DREAD, ccwait all 0, dload[0]=ramload.
